stopwatch_ctrl: RTL and testbench

- Stopwatch sequencer driven by the 50 ms divided clock from the clock divider.
- Resynchronises the divider output into a single-cycle tick and runs a start/stop/lap/clear state machine from debounced button pulses.
- Maintains a minutes:seconds:ticks count and a lap-freezable display value for the seven-segment/display mux.

---
 rtl/stopwatch_ctrl.sv | 139 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: resyncs the 50 ms divided clock into a one-cycle tick and runs
// the start/stop/lap/clear FSM. Define STOPWATCH_SATURATE_EN to hold at max on overflow.
module stopwatch_ctrl #(
  parameter int TICKS_PER_SEC = 20,
  parameter int MAX_MIN       = 99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       running,
  output logic       lap_active,
  output logic       ovf,
  output logic [6:0] disp_min,
  output logic [5:0] disp_sec,
  output logic [4:0] disp_tick
);

  localparam logic [4:0] TICK_MAX = 5'(TICKS_PER_SEC - 1);
  localparam logic [6:0] MIN_MAX  = 7'(MAX_MIN);

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  typedef struct packed {
    logic [6:0] min;
    logic [5:0] sec;
    logic [4:0] tk;
  } cnt_t;

  state_t     state, state_n;
  cnt_t       cnt, cnt_n, lap, lap_n, disp_v;
  logic       ovf_n, cnt_en, at_max;
  logic       s1, s2, s3, armed, tick_p;
  logic [1:0] vld_pipe;
`ifdef STOPWATCH_SATURATE_EN
  logic       sat_hit;
`endif

  // vld_pipe marks sync stages holding real post-reset samples, so the reset
  // zero in s2 never arms edge detection on its own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      vld_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      s1       <= tick_in;
      s2       <= s1;
      s3       <= s2;
      vld_pipe <= {vld_pipe[0], 1'b1};
      if (vld_pipe[1] && !s2) armed <= 1'b1;
    end
  end

  assign tick_p = armed & s2 & ~s3;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lap_n   = lap;
    ovf_n   = ovf;
    cnt_en  = (state == RUN) || (state == LAP);
    at_max  = (cnt.min == MIN_MAX) && (cnt.sec == 6'd59) && (cnt.tk == TICK_MAX);
`ifdef STOPWATCH_SATURATE_EN
    sat_hit = 1'b0;
`endif
    if (cnt_en && tick_p) begin
      if (at_max) begin
        ovf_n = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
        sat_hit = 1'b1;
`else
        cnt_n = '0;
`endif
      end else if (cnt.tk == TICK_MAX) begin
        cnt_n.tk = '0;
        if (cnt.sec == 6'd59) begin
          cnt_n.sec = '0;
          cnt_n.min = cnt.min + 7'd1;
        end else begin
          cnt_n.sec = cnt.sec + 6'd1;
        end
      end else begin
        cnt_n.tk = cnt.tk + 5'd1;
      end
    end
    // btn_ss always wins over btn_lr; lap captures the pre-tick count
    case (state)
      IDLE:  if (btn_ss) state_n = RUN;
      RUN:   if (btn_ss) state_n = PAUSE;
             else if (btn_lr) begin
               state_n = LAP;
               lap_n   = cnt;
             end
      LAP:   if (btn_ss) state_n = PAUSE;
             else if (btn_lr) state_n = RUN;
      PAUSE: if (btn_ss) state_n = RUN;
             else if (btn_lr) begin
               state_n = IDLE;
               cnt_n   = '0;
               lap_n   = '0;
               ovf_n   = 1'b0;
             end
      default: state_n = IDLE;
    endcase
`ifdef STOPWATCH_SATURATE_EN
    if (sat_hit) state_n = PAUSE;
`endif
    disp_v = (state_n == LAP) ? lap_n : cnt_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lap        <= '0;
      ovf        <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      disp_min   <= '0;
      disp_sec   <= '0;
      disp_tick  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lap        <= lap_n;
      ovf        <= ovf_n;
      running    <= (state_n == RUN) || (state_n == LAP);
      lap_active <= (state_n == LAP);
      disp_min   <= disp_v.min;
      disp_sec   <= disp_v.sec;
      disp_tick  <= disp_v.tk;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: an integer-count reference model queues the
// expected outputs per clock; a monitor pops and compares them away from the edge.
module tb_stopwatch_ctrl;
  localparam int TPS    = 4;
  localparam int MAXM   = 1;
  localparam int MAXTOT = (MAXM * 60 + 59) * TPS + TPS - 1;

  logic clk = 1'b0;
  logic reset_n, tick_in, btn_ss, btn_lr;
  logic running, lap_active, ovf;
  logic [6:0] disp_min;
  logic [5:0] disp_sec;
  logic [4:0] disp_tick;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICKS_PER_SEC(TPS), .MAX_MIN(MAXM)) dut (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .running(running), .lap_active(lap_active), .ovf(ovf),
    .disp_min(disp_min), .disp_sec(disp_sec), .disp_tick(disp_tick)
  );

  typedef struct {
    int    cyc;
    bit    run;
    bit    lapa;
    bit    ovf;
    int    mn;
    int    sc;
    int    tk;
    string tag;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_LAP, M_PAUSE} mst_t;

  exp_t  q[$];
  int    checks = 0, failures = 0, cyc = 0;
  event  async_chk;
  mst_t  st;
  int    total, lap_tot;
  bit    m_ovf, rst_drv;
  bit    hist[$];
  string tag = "init";

  function automatic void m_reset();
    st = M_IDLE; total = 0; lap_tot = 0; m_ovf = 0;
    hist.delete();
  endfunction

  // Reference: a tick counts on the 3rd edge after tick_in rises, provided the
  // preceding low was sampled after reset. The count is one integer of ticks.
  function automatic void model_edge(bit t, bit ss, bit lr);
    bit tk, cnt_en;
    int pre;
`ifdef STOPWATCH_SATURATE_EN
    bit sat_stop = 0;
`endif
    if (!rst_drv) begin
      m_reset();
      return;
    end
    tk = (hist.size() >= 3) && hist[hist.size()-2] && !hist[hist.size()-3];
    hist.push_back(t);
    if (hist.size() > 4) void'(hist.pop_front());
    pre    = total;
    cnt_en = (st == M_RUN) || (st == M_LAP);
    if (st == M_PAUSE && lr && !ss) begin
      st = M_IDLE; total = 0; lap_tot = 0; m_ovf = 0;
      return;
    end
    if (cnt_en && tk) begin
      if (total == MAXTOT) begin
        m_ovf = 1;
`ifdef STOPWATCH_SATURATE_EN
        sat_stop = 1;
`else
        total = 0;
`endif
      end else total++;
    end
    case (st)
      M_IDLE:  if (ss) st = M_RUN;
      M_RUN:   if (ss) st = M_PAUSE; else if (lr) begin st = M_LAP; lap_tot = pre; end
      M_LAP:   if (ss) st = M_PAUSE; else if (lr) st = M_RUN;
      M_PAUSE: if (ss) st = M_RUN;
    endcase
`ifdef STOPWATCH_SATURATE_EN
    if (sat_stop) st = M_PAUSE;
`endif
  endfunction

  function automatic void push_exp();
    exp_t e;
    int v;
    v      = (st == M_LAP) ? lap_tot : total;
    e.cyc  = cyc;
    e.run  = (st == M_RUN) || (st == M_LAP);
    e.lapa = (st == M_LAP);
    e.ovf  = m_ovf;
    e.mn   = v / (60 * TPS);
    e.sc   = (v / TPS) % 60;
    e.tk   = v % TPS;
    e.tag  = tag;
    q.push_back(e);
  endfunction

  task automatic step(bit t, bit ss, bit lr);
    @(negedge clk);
    #1;
    reset_n = rst_drv; tick_in = t; btn_ss = ss; btn_lr = lr;
    @(posedge clk);
    cyc++;
    model_edge(t, ss, lr);
    push_exp();
  endtask

  // One tick_in period: 3 high cycles (the 3rd is the counting edge), 3 low.
  task automatic tick_period(bit ss_hi, bit lr_hi, bit ss_lo, bit lr_lo);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, ss_hi, lr_hi);
    step(0, ss_lo, lr_lo);
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk or async_chk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (running !== e.run || lap_active !== e.lapa || ovf !== e.ovf ||
            disp_min != e.mn || disp_sec != e.sc || disp_tick != e.tk) begin
          failures++;
          $display("FAIL %s cyc=%0d got run=%0d lap=%0d ovf=%0d disp=%0d:%0d:%0d expected run=%0d lap=%0d ovf=%0d disp=%0d:%0d:%0d",
                   e.tag, e.cyc, running, lap_active, ovf, disp_min, disp_sec, disp_tick,
                   e.run, e.lapa, e.ovf, e.mn, e.sc, e.tk);
        end
      end
    end
  end

  initial begin
    rst_drv = 0; reset_n = 0; tick_in = 1; btn_ss = 0; btn_lr = 0;
    m_reset();
    tag = "reset";          repeat (3) step(1, 0, 0);
    rst_drv = 1;
    tag = "release_high";   repeat (4) step(1, 0, 0);
    tag = "start_high";     step(1, 1, 0); repeat (4) step(1, 0, 0);
    tag = "first_low";      repeat (3) step(0, 0, 0);
    tag = "count25";        repeat (25) tick_period(0, 0, 0, 0);
    tag = "lap_freeze";     step(0, 0, 1); repeat (30) tick_period(0, 0, 0, 0);
    tag = "lap_release";    step(0, 0, 1);
    tag = "run_ss_tick";    tick_period(1, 0, 0, 0);
    tag = "pause_ss_tick";  tick_period(1, 0, 0, 0);
    tag = "pause_both";     tick_period(0, 0, 1, 0); tick_period(0, 0, 1, 1);
    tag = "pause_clr_tick"; tick_period(0, 0, 1, 0); tick_period(0, 1, 0, 0);
    tag = "idle_ticks";     repeat (4) tick_period(0, 0, 0, 0);
    tag = "random";
    repeat (60) tick_period(0, 0, ($urandom % 4) == 0, ($urandom % 4) == 0);
    tag = "async_reset";
    if (st != M_RUN && st != M_LAP) step(0, 1, 0);
    repeat (3) tick_period(0, 0, 0, 0);
    @(negedge clk);
    #2;
    reset_n = 0; rst_drv = 0;
    m_reset();
    #1;
    push_exp();
    -> async_chk;
    repeat (2) step(0, 0, 0);
    rst_drv = 1;
    tag = "post_reset";     repeat (2) step(0, 0, 0);
    tag = "overflow";       step(0, 1, 0); repeat (MAXTOT + 1) tick_period(0, 0, 0, 0);
    tag = "after_ovf";      repeat (2) tick_period(0, 0, 0, 0);
    tag = "ovf_clear";
    if (st == M_RUN || st == M_LAP) step(0, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain pending=%0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
